// File: rtl/dmem_pkg.sv
// dmem_pkg: definitions shared by the data-memory responder and the core-side adapter.
//   dmem_state_t : responder FSM states
//   WORD_W       : data word width
//   OP_LW/OP_SW  : core opcodes that the adapter decodes into memory requests
//   addr_err()   : flags misaligned byte addresses or addresses above the memory
package dmem_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    // Any bit above the word index must be zero, so addresses never alias into the array.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                      input int unsigned       idx_w);
        return (addr[1:0] != 2'b00) || ((addr >> (idx_w + 2)) != '0);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous word RAM, no reset (contents undefined until written).
//   clk   : clock
//   we    : write enable for word idx
//   idx   : word index
//   wdata : write data
//   rdata : registered read data of idx (old contents when written on the same edge)
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
        r_rdata <= r_mem[idx];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core's data-memory interface.
//   clk, rst               : clock, asynchronous active-high reset
//   req_valid/req_ready    : request handshake (one outstanding request)
//   req_we/addr/wdata      : store flag, byte address, store data
//   rsp_valid/rsp_ready    : response handshake
//   rsp_rdata/rsp_err      : load data (0 for stores/errors), access error flag
// A request waits LATENCY cycles, then the access is performed and the response is held
// until consumed. Misaligned or out-of-range accesses report rsp_err and never write.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    dmem_state_t       r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_rsp_load;

    logic              w_accept;
    logic              w_access;
    logic              w_acc_we;
    logic              w_acc_err;
    logic              w_ram_we;
    logic [WORD_W-1:0] w_acc_addr;
    logic [WORD_W-1:0] w_acc_wdata;
    logic [WORD_W-1:0] w_ram_rdata;
    logic [IDX_W-1:0]  w_ram_idx;

    // In IDLE the access uses the live request so a zero-latency access can happen on the
    // accept edge; otherwise it uses the latched request.
    always_comb begin
        w_accept    = (r_state == IDLE) && req_valid;
        w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
        w_acc_we    = (r_state == IDLE) ? req_we    : r_we;
        w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
        w_access    = (w_accept && (LATENCY == 0)) || ((r_state == WAIT) && (r_cnt == 4'd1));
        w_acc_err   = addr_err(w_acc_addr, IDX_W);
        w_ram_we    = w_access && w_acc_we && !w_acc_err && !rst;
        w_ram_idx   = w_acc_addr[IDX_W+1:2];
    end

    dmem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .idx   (w_ram_idx),
        .wdata (w_acc_wdata),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_acc_err;
                            r_rsp_load  <= !w_acc_we && !w_acc_err;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= 4'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_acc_err;
                        r_rsp_load  <= !w_acc_we && !w_acc_err;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_load  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_load  <= 1'b0;
                end
            endcase
        end
    end

    // The RAM keeps re-reading the latched word while in RESP, so load data stays stable.
    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_load ? w_ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses LATENCY=2, instance 1 uses LATENCY=0.
// A cycle-level transaction model checks every output each cycle; directed sequences
// pin the model with hand-computed literals.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;

    logic              clk;
    logic [1:0]        rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [1:0][31:0]  rsp_rdata;
    logic [1:0]        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut_l2 (
        .clk       (clk),
        .rst       (rst[0]),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_we    (req_we[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut_l0 (
        .clk       (clk),
        .rst       (rst[1]),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_we    (req_we[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // ---------------- transaction-level model ----------------
    logic [31:0] m_mem   [2][DEPTH];
    bit          m_known [2][DEPTH];
    bit   [1:0]        m_busy;
    bit   [1:0]        m_resp;
    int                m_resp_edge [2];
    logic [1:0]        m_we;
    logic [1:0][31:0]  m_addr;
    logic [1:0][31:0]  m_wdata;
    logic [1:0][31:0]  m_exp_rdata;
    logic [1:0]        m_exp_err;
    bit   [1:0]        m_exp_chk;

    task automatic model_access(input int d);
        int unsigned w;
        bit          err;
        err = (m_addr[d] % 4 != 0) || (m_addr[d] >= 32'(4 * DEPTH));
        m_exp_err[d]   = err;
        m_exp_rdata[d] = 32'h0;
        m_exp_chk[d]   = 1'b1;
        if (!err) begin
            w = m_addr[d] / 4;
            if (m_we[d]) begin
                m_mem[d][w]   = m_wdata[d];
                m_known[d][w] = 1'b1;
            end else begin
                m_exp_rdata[d] = m_mem[d][w];
                m_exp_chk[d]   = m_known[d][w];
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                chk($sformatf("rst_req_ready%0d", d), 32'(req_ready[d]), 32'd1);
                chk($sformatf("rst_rsp_valid%0d", d), 32'(rsp_valid[d]), 32'd0);
                chk($sformatf("rst_rsp_rdata%0d", d), rsp_rdata[d], 32'd0);
                chk($sformatf("rst_rsp_err%0d", d), 32'(rsp_err[d]), 32'd0);
                m_busy[d] = 1'b0;
                m_resp[d] = 1'b0;
            end else begin
                if (m_busy[d] && !m_resp[d] && cyc == m_resp_edge[d]) begin
                    model_access(d);
                    m_resp[d] = 1'b1;
                end
                if (!m_busy[d]) begin
                    chk($sformatf("idle_req_ready%0d", d), 32'(req_ready[d]), 32'd1);
                    chk($sformatf("idle_rsp_valid%0d", d), 32'(rsp_valid[d]), 32'd0);
                    if (req_valid[d]) begin
                        m_busy[d]      = 1'b1;
                        m_we[d]        = req_we[d];
                        m_addr[d]      = req_addr[d];
                        m_wdata[d]     = req_wdata[d];
                        m_resp_edge[d] = cyc + 1 + lat_of(d);
                    end
                end else if (!m_resp[d]) begin
                    chk($sformatf("wait_req_ready%0d", d), 32'(req_ready[d]), 32'd0);
                    chk($sformatf("wait_rsp_valid%0d", d), 32'(rsp_valid[d]), 32'd0);
                end else begin
                    chk($sformatf("resp_valid%0d", d), 32'(rsp_valid[d]), 32'd1);
                    chk($sformatf("resp_req_ready%0d", d), 32'(req_ready[d]), 32'd0);
                    chk($sformatf("resp_err%0d", d), 32'(rsp_err[d]), 32'(m_exp_err[d]));
                    if (m_exp_chk[d]) begin
                        chk($sformatf("resp_rdata%0d", d), rsp_rdata[d], m_exp_rdata[d]);
                    end
                    if (rsp_ready[d]) begin
                        m_busy[d] = 1'b0;
                        m_resp[d] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // One transaction on instance d; edges counts edges from the accept edge (inclusive)
    // to the first cycle rsp_valid is seen. poke raises req_valid during the stall.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold, input bit poke,
                       output logic [31:0] rdata, output logic err, output int edges);
        int k;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        rsp_ready[d] = 1'b0;
        k = 0;
        @(negedge clk);
        while (!req_ready[d] && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready[d]) chk("accept_timeout", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        edges = 1;
        @(negedge clk);
        while (!rsp_valid[d] && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (poke) begin
                req_valid[d] = 1'b1;
                req_we[d]    = 1'b1;
                req_addr[d]  = 32'h20;
                req_wdata[d] = 32'h12345678;
            end
            @(negedge clk);
            chk("stall_req_ready", 32'(req_ready[d]), 32'd0);
            chk("stall_rdata", rsp_rdata[d], rdata);
            chk("stall_err", 32'(rsp_err[d]), 32'(err));
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        @(negedge clk);
        chk("ready_after_hs", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    logic        er;
    int          ed;
    logic [31:0] tp_rsp [16];
    int          tp_acc [16];
    int          nr, idx, t;

    initial begin
        rst       = 2'b11;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '0;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'h3);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 2'b00;

        // LATENCY=2 store/load
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd, er, ed);
        chk("sw10_latency", 32'(ed), 32'd3);
        chk("sw10_err", 32'(er), 32'd0);
        chk("sw10_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er, ed);
        chk("lw10_latency", 32'(ed), 32'd3);
        chk("lw10_rdata", rd, 32'hDEADBEEF);
        // misaligned store does not write
        txn(0, 1'b1, 32'h13, 32'h0BADF00D, 0, 1'b0, rd, er, ed);
        chk("sw13_err", 32'(er), 32'd1);
        chk("sw13_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er, ed);
        chk("lw10_after_mis", rd, 32'hDEADBEEF);
        // range edges and no wrap-around
        txn(0, 1'b1, 32'h0, 32'h00C0FFEE, 0, 1'b0, rd, er, ed);
        txn(0, 1'b1, 32'h400, 32'hFFFFFFFF, 0, 1'b0, rd, er, ed);
        chk("sw400_err", 32'(er), 32'd1);
        txn(0, 1'b0, 32'h0, 32'h0, 0, 1'b0, rd, er, ed);
        chk("lw0_no_alias", rd, 32'h00C0FFEE);
        txn(0, 1'b0, 32'h3FC, 32'h0, 0, 1'b0, rd, er, ed);
        chk("lw3fc_err", 32'(er), 32'd0);
        txn(0, 1'b1, 32'h3FC, 32'h3FC3FC00, 0, 1'b0, rd, er, ed);
        txn(0, 1'b0, 32'h3FC, 32'h0, 0, 1'b0, rd, er, ed);
        chk("lw3fc_rdata", rd, 32'h3FC3FC00);
        txn(0, 1'b0, 32'h400, 32'h0, 0, 1'b0, rd, er, ed);
        chk("lw400_err", 32'(er), 32'd1);
        chk("lw400_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h80000010, 32'h0, 0, 1'b0, rd, er, ed);
        chk("lw_hibit_err", 32'(er), 32'd1);
        // backpressure with an ignored request during the stall
        txn(0, 1'b0, 32'h10, 32'h0, 5, 1'b1, rd, er, ed);
        chk("bp_rdata", rd, 32'hDEADBEEF);
        txn(0, 1'b0, 32'h20, 32'h0, 0, 1'b0, rd, er, ed);
        chk("bp_poke_ignored_err", 32'(er), 32'd0);

        // reset during WAIT drops the pending store
        txn(0, 1'b1, 32'h40, 32'h11111111, 0, 1'b0, rd, er, ed);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h40;
        req_wdata[0] = 32'hCAFEF00D;
        @(negedge clk);
        chk("rst_seq_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        #1;
        chk("async_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("async_rst_req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        txn(0, 1'b0, 32'h40, 32'h0, 0, 1'b0, rd, er, ed);
        chk("lw40_store_dropped", rd, 32'h11111111);

        // LATENCY=0 back-to-back: SW/LW pairs to 0x0..0x1C
        nr  = 0;
        idx = 0;
        t   = 0;
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h0;
        req_wdata[1] = 32'hA5A50000;
        while (idx < 16 && t < 200) begin
            @(negedge clk);
            t++;
            if (rsp_valid[1] && nr < 16) begin
                tp_rsp[nr] = rsp_rdata[1];
                nr++;
            end
            if (req_ready[1]) begin
                tp_acc[idx] = cyc;
                idx++;
                @(posedge clk);
                #1;
                if (idx < 16) begin
                    req_we[1]    = (idx % 2 == 0);
                    req_addr[1]  = 32'((idx / 2) * 4);
                    req_wdata[1] = 32'hA5A50000 | 32'(idx / 2);
                end else begin
                    req_valid[1] = 1'b0;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid[1] && nr < 16) begin
                tp_rsp[nr] = rsp_rdata[1];
                nr++;
            end
        end
        rsp_ready[1] = 1'b0;
        chk("tp_accepts", 32'(idx), 32'd16);
        chk("tp_responses", 32'(nr), 32'd16);
        for (int i = 1; i < idx; i++) begin
            chk($sformatf("tp_spacing%0d", i), 32'(tp_acc[i] - tp_acc[i-1]), 32'd2);
        end
        for (int i = 0; i < nr; i++) begin
            if (i % 2 == 0) chk($sformatf("tp_sw%0d", i), tp_rsp[i], 32'd0);
            else chk($sformatf("tp_lw%0d", i), tp_rsp[i], 32'hA5A50000 | 32'(i / 2));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the processor's data-memory interface: accepts one load/store request at a time from the core's LW/SW path over a valid/ready handshake and returns read data (or a write acknowledge) after a programmable number of wait states. Replaces the combinational data memory so the core can run against realistic multi-cycle memory timing. Flags misaligned and out-of-range accesses instead of silently aliasing.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: wait states between request acceptance and response; range 0–15.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store (SW), 0 = load (LW).
- `req_addr`  in  32  byte address from the ALU result.
- `req_wdata`  in  32  store data (Rt).
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  core consumes the response.
- `rsp_rdata`  out  32  load data; 0 for stores and for errors.
- `rsp_err`  out  1  access was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On an edge with `req_valid`: latch `req_we`, `req_addr`, `req_wdata`; load the wait counter with `LATENCY`; go to WAIT. If `LATENCY`=0, go directly to RESP with the access performed on that edge.
- WAIT: `req_ready`=0. Decrement the counter each edge. On the edge where the counter is 1, perform the access and go to RESP.
- Access:
  - Word index = `addr[log2(DEPTH)+1:2]`.
  - Error if `addr[1:0]`≠0, or if any bit of `addr[31:log2(DEPTH)+2]` ≠ 0.
  - On error: no write occurs, `rsp_rdata`=0, `rsp_err`=1.
  - Otherwise a store writes `wdata` to the word and returns `rsp_rdata`=0; a load returns the word.
- RESP: `rsp_valid`=1. `rsp_rdata` and `rsp_err` are held stable until the edge with `rsp_ready`=1, then go to IDLE.
- Only one request is outstanding. `req_valid` outside IDLE is ignored and not queued.
- Memory contents are not cleared by reset and are undefined before the first write.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state IDLE, counter 0.
- Latency: `rsp_valid` rises exactly `LATENCY`+1 edges after the accept edge.
- Back-to-back: with `rsp_ready` tied high, a new request is accepted every `LATENCY`+2 cycles. `req_ready` returns one cycle after the response handshake.
- Read-after-write to the same word returns the newly written data. This follows from strict serialisation.
- Store/load ordering is exactly handshake order.
- Reset mid-operation (WAIT or RESP):
  - Outputs return to reset values immediately, asynchronously.
  - A store whose write edge has not yet occurred is dropped.
  - A store already written stays written.
- Response stall: `rsp_ready` low for any number of cycles keeps state in RESP with outputs frozen.
- Address boundaries:
  - `req_addr` = 4·(`DEPTH`−1) is legal.
  - `req_addr` = 4·`DEPTH` is an error.
  - Wrap-around aliasing is forbidden.

## Structure
- Shared package `dmem_pkg`:
  - state enum `dmem_state_t` {IDLE, WAIT, RESP};
  - `WORD_W`=32;
  - core opcode constants `OP_LW`=6'b100011 and `OP_SW`=6'b101011, used by the core-side adapter.
- Sub-module `dmem_ram`:
  - single-port synchronous word RAM with parameter `DEPTH`;
  - ports `clk`, `we`, `idx`, `wdata`, `rdata`;
  - no reset.
- The FSM, counter, error check and response registers live in `dmem_responder`.

## Test plan
- Reset then idle: `rst` pulse during WAIT -> `rsp_valid`=0 and `req_ready`=1 in the same cycle; FSM returns to IDLE.
- Store/load, `LATENCY`=2:
  - SW `addr`=0x10, `wdata`=0xDEADBEEF -> `rsp_valid` 3 edges after accept, `rsp_err`=0, `rsp_rdata`=0.
  - LW 0x10 -> `rsp_rdata`=0xDEADBEEF.
- Misaligned: SW 0x13 -> `rsp_err`=1. A subsequent LW 0x10 still returns the prior value (no write occurred).
- Range edge, `DEPTH`=256:
  - LW 0x3FC -> `rsp_err`=0.
  - LW 0x400 -> `rsp_err`=1, `rsp_rdata`=0.
  - SW 0x400 does not corrupt word 0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles -> `rsp_rdata` and `rsp_err` are stable. `req_valid` asserted during the stall is ignored (`req_ready`=0). `req_ready` rises one cycle after the handshake.
- `LATENCY`=0 throughput: 8 alternating SW/LW to 0x0–0x1C with `rsp_ready`=1 -> one accept every 2 cycles; every load returns the immediately preceding store value.
